// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised SRAM bank: FSM state encoding,
// byte-lane width and the byte-enable to bit-mask expansion.
package sram_pkg;

    typedef enum logic {
        SRAM_INIT,
        SRAM_READY
    } sram_state_t;

    localparam int BYTE_W  = 8;
    // Widest word the mask helper supports; banks slice the low sram_bit bits.
    localparam int MAX_BIT = 1024;
    localparam int MAX_NB  = MAX_BIT / BYTE_W;

    // Active-low byte enables in, active-high bit mask out (1 = bit gets written).
    function automatic logic [MAX_BIT-1:0] byte_mask(input logic [MAX_NB-1:0] bwen);
        logic [MAX_BIT-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_NB; i++) begin
            mask[i*BYTE_W +: BYTE_W] = {BYTE_W{~bwen[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sram_out_stage.sv
// Optional output pipeline register for the SRAM bank: Q loads only on a valid
// read so it holds between reads; QV is a one-cycle strobe.
module sram_out_stage #(
    parameter int WIDTH = 128
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             rd_valid,
    output logic [WIDTH-1:0] Q,
    output logic             QV
);

    always_ff @(posedge CLK) begin
        if (reset) begin
            Q  <= '0;
            QV <= 1'b0;
        end else begin
            QV <= rd_valid;
            if (rd_valid) begin
                Q <= rd_data;
            end
        end
    end

endmodule

// File: rtl/sram_bank_p.sv
// Parametrised single-port SRAM bank with byte-write masking, read-valid strobe
// and optional output register. Define SRAM_RESET_CLEAR_EN to zero the array after reset.
module sram_bank_p
    import sram_pkg::*;
#(
    parameter int  sram_bit = 128,
    parameter int  depth    = 16,
    parameter int  OUT_REG  = 0,
    localparam int ADDR_W   = $clog2(depth),
    localparam int NB       = sram_bit / 8
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                CEN,
    input  logic                WEN,
    input  logic [ADDR_W-1:0]   A,
    input  logic [sram_bit-1:0] D,
    input  logic [NB-1:0]       BWEN,
    output logic [sram_bit-1:0] Q,
    output logic                QV,
    output logic                RDY
);

    sram_state_t         state;
    logic                rdy;
    logic [sram_bit-1:0] mem [0:depth-1];
    logic                in_range;
    logic                rd_en;
    logic                wr_en;
    logic [MAX_NB-1:0]   bwen_wide;
    logic [MAX_BIT-1:0]  mask_wide;
    logic [sram_bit-1:0] bit_mask;
    logic [sram_bit-1:0] q_core;
    logic                qv_core;
`ifdef SRAM_RESET_CLEAR_EN
    logic [ADDR_W-1:0]   clr_cnt;
`endif

    // A power-of-two depth decodes every address; otherwise guard the tail.
    generate
        if (depth == (1 << ADDR_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (int'(A) < depth);
        end
    endgenerate

    always_comb begin
        bwen_wide         = '1;
        bwen_wide[NB-1:0] = BWEN;
        mask_wide         = byte_mask(bwen_wide);
    end

    assign bit_mask = mask_wide[sram_bit-1:0];

    generate
        if (sram_bit < MAX_BIT) begin : g_mask_sink
            logic unused_mask;
            assign unused_mask = ^mask_wide[MAX_BIT-1:sram_bit];
        end
    endgenerate

    assign rd_en = ~reset & rdy & ~CEN &  WEN & in_range;
    assign wr_en = ~reset & rdy & ~CEN & ~WEN & in_range;

    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= SRAM_INIT;
            rdy     <= 1'b0;
`ifdef SRAM_RESET_CLEAR_EN
            clr_cnt <= '0;
`endif
        end else begin
            case (state)
                SRAM_INIT: begin
`ifdef SRAM_RESET_CLEAR_EN
                    if (clr_cnt == ADDR_W'(depth - 1)) begin
                        state <= SRAM_READY;
                        rdy   <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
`else
                    state <= SRAM_READY;
                    rdy   <= 1'b1;
`endif
                end
                SRAM_READY: begin
                    rdy <= 1'b1;
                end
                default: begin
                    state <= SRAM_INIT;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array has no reset branch; a reset on a memory turns it into
    // depth*sram_bit flops. Zeroing, when wanted, is done by the INIT sweep.
    always_ff @(posedge CLK) begin
`ifdef SRAM_RESET_CLEAR_EN
        if (!reset && state == SRAM_INIT) begin
            mem[clr_cnt] <= '0;
        end else
`endif
        if (wr_en) begin
            mem[A] <= (mem[A] & ~bit_mask) | (D & bit_mask);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            q_core  <= '0;
            qv_core <= 1'b0;
        end else begin
            qv_core <= rd_en;
            if (rd_en) begin
                q_core <= mem[A];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            sram_out_stage #(
                .WIDTH (sram_bit)
            ) u_out_stage (
                .CLK      (CLK),
                .reset    (reset),
                .rd_data  (q_core),
                .rd_valid (qv_core),
                .Q        (Q),
                .QV       (QV)
            );
        end else begin : g_no_out_reg
            assign Q  = q_core;
            assign QV = qv_core;
        end
    endgenerate

    assign RDY = rdy;

endmodule

// File: tb/tb_sram_bank_p.sv
// Directed bench for sram_bank_p: a depth-12 latency-1 bank and a depth-16
// latency-2 bank share one stimulus stream and are checked against hand values.
module tb_sram_bank_p;

    localparam int W  = 128;
    localparam int NB = W / 8;

`ifdef SRAM_RESET_CLEAR_EN
    localparam int EXP_RDY_A = 12;
    localparam int EXP_RDY_B = 16;
`else
    localparam int EXP_RDY_A = 1;
    localparam int EXP_RDY_B = 1;
`endif

    localparam logic [W-1:0] D1  = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [W-1:0] D2  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [W-1:0] D3  = 128'h11112222_33334444_55556666_77778888;
    localparam logic [W-1:0] M1  = {{15{8'hAA}}, 8'h55};
    localparam logic [W-1:0] M2  = {8'h00, {14{8'hAA}}, 8'h55};

    logic          CLK = 1'b0;
    logic          reset;
    logic          CEN;
    logic          WEN;
    logic [3:0]    A;
    logic [W-1:0]  D;
    logic [NB-1:0] BWEN;
    logic [W-1:0]  q_a, q_b;
    logic          qv_a, qv_b, rdy_a, rdy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int fa, fb;

    always #5 CLK = ~CLK;

    sram_bank_p #(.sram_bit(W), .depth(12), .OUT_REG(0)) u_a (
        .CLK(CLK), .reset(reset), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .BWEN(BWEN),
        .Q(q_a), .QV(qv_a), .RDY(rdy_a)
    );

    sram_bank_p #(.sram_bit(W), .depth(16), .OUT_REG(1)) u_b (
        .CLK(CLK), .reset(reset), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .BWEN(BWEN),
        .Q(q_b), .QV(qv_b), .RDY(rdy_b)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        CEN  = 1'b1;
        WEN  = 1'b1;
        A    = '0;
        D    = '0;
        BWEN = '1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [W-1:0] data, input logic [NB-1:0] bwen);
        CEN  = 1'b0;
        WEN  = 1'b0;
        A    = addr;
        D    = data;
        BWEN = bwen;
        step();
        idle();
        check("wr_qv_a", {127'b0, qv_a}, '0);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] addr,
                            input logic [W-1:0] ea, input logic eva,
                            input logic [W-1:0] eb, input logic evb);
        CEN = 1'b0;
        WEN = 1'b1;
        A   = addr;
        step();
        idle();
        check({tag, "_q_a"},  q_a, ea);
        check({tag, "_qv_a"}, {127'b0, qv_a}, {127'b0, eva});
        check({tag, "_qv_b_early"}, {127'b0, qv_b}, '0);
        step();
        check({tag, "_q_b"},  q_b, eb);
        check({tag, "_qv_b"}, {127'b0, qv_b}, {127'b0, evb});
        check({tag, "_qv_a_pulse"}, {127'b0, qv_a}, '0);
    endtask

    // Counts edges since reset release until each RDY rises; 0 means it never did.
    task automatic wait_rdy(input int start, output int first_a, output int first_b);
        first_a = rdy_a ? start : 0;
        first_b = rdy_b ? start : 0;
        for (int c = start + 1; c <= 64 && (first_a == 0 || first_b == 0); c++) begin
            step();
            if (rdy_a && first_a == 0) first_a = c;
            if (rdy_b && first_b == 0) first_b = c;
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge CLK);
        step();
        step();
        check("rst_q_a",   q_a, '0);
        check("rst_qv_a",  {127'b0, qv_a}, '0);
        check("rst_rdy_a", {127'b0, rdy_a}, '0);
        check("rst_q_b",   q_b, '0);
        check("rst_qv_b",  {127'b0, qv_b}, '0);
        check("rst_rdy_b", {127'b0, rdy_b}, '0);

        // Read presented during INIT must be ignored.
        CEN   = 1'b0;
        WEN   = 1'b1;
        A     = 4'd2;
        reset = 1'b0;
        step();
        idle();
        check("init_rd_qv_a", {127'b0, qv_a}, '0);
        check("init_rd_q_a",  q_a, '0);
        wait_rdy(1, fa, fb);
        check("rdy_rise_a", W'(fa), W'(EXP_RDY_A));
        check("rdy_rise_b", W'(fb), W'(EXP_RDY_B));
        step();
        check("init_rd_qv_b", {127'b0, qv_b}, '0);
        check("init_rd_q_b",  q_b, '0);

`ifdef SRAM_RESET_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            rd_check("clr", 4'(i), '0, (i < 12), '0, 1'b1);
        end
`endif

        // Chip disabled: no read strobe, Q untouched.
        CEN = 1'b1;
        WEN = 1'b1;
        A   = 4'd3;
        step();
        check("cen_qv_a", {127'b0, qv_a}, '0);
        check("cen_q_a",  q_a, '0);
        step();
        check("cen_qv_b", {127'b0, qv_b}, '0);
        check("cen_q_b",  q_b, '0);

        // Full write, read-after-write next cycle.
        wr(4'd3, D1, '0);
        rd_check("full", 4'd3, D1, 1'b1, D1, 1'b1);

        // Byte masking: only byte 0, then only byte 15, then no lanes.
        wr(4'd5, {16{8'hAA}}, 16'h0000);
        wr(4'd5, {16{8'h55}}, 16'hFFFE);
        rd_check("mask0", 4'd5, M1, 1'b1, M1, 1'b1);
        wr(4'd5, '0, 16'h7FFF);
        rd_check("mask15", 4'd5, M2, 1'b1, M2, 1'b1);
        wr(4'd5, '1, 16'hFFFF);
        rd_check("mask_none", 4'd5, M2, 1'b1, M2, 1'b1);

        // Address 13 is beyond bank A but valid for bank B.
        wr(4'd11, D3, '0);
        wr(4'd13, D2, '0);
        rd_check("oor13", 4'd13, M2, 1'b0, D2, 1'b1);
        rd_check("edge11", 4'd11, D3, 1'b1, D3, 1'b1);

        // Write with CEN high is dropped.
        CEN = 1'b1;
        WEN = 1'b0;
        A   = 4'd3;
        D   = D2;
        BWEN = '0;
        step();
        idle();
        rd_check("cen_wr", 4'd3, D1, 1'b1, D1, 1'b1);

        // Back-to-back reads stream through both latencies.
        CEN = 1'b0;
        WEN = 1'b1;
        A   = 4'd3;
        step();
        check("bb1_q_a",  q_a, D1);
        check("bb1_qv_a", {127'b0, qv_a}, 128'd1);
        A = 4'd11;
        step();
        idle();
        check("bb2_q_a",  q_a, D3);
        check("bb2_qv_a", {127'b0, qv_a}, 128'd1);
        check("bb1_q_b",  q_b, D1);
        check("bb1_qv_b", {127'b0, qv_b}, 128'd1);
        step();
        check("bb3_qv_a", {127'b0, qv_a}, '0);
        check("bb2_q_b",  q_b, D3);
        check("bb2_qv_b", {127'b0, qv_b}, 128'd1);
        step();
        check("bb3_qv_b", {127'b0, qv_b}, '0);

        // Reset while bank B still has a read in its output stage.
        CEN = 1'b0;
        WEN = 1'b1;
        A   = 4'd11;
        step();
        check("mid_q_a",  q_a, D3);
        check("mid_qv_a", {127'b0, qv_a}, 128'd1);
        idle();
        reset = 1'b1;
        step();
        check("mid_rst_q_b",   q_b, '0);
        check("mid_rst_qv_b",  {127'b0, qv_b}, '0);
        check("mid_rst_q_a",   q_a, '0);
        check("mid_rst_rdy_a", {127'b0, rdy_a}, '0);
        check("mid_rst_rdy_b", {127'b0, rdy_b}, '0);
        reset = 1'b0;

`ifdef SRAM_RESET_CLEAR_EN
        repeat (7) step();
        check("sweep7_rdy_a", {127'b0, rdy_a}, '0);
        check("sweep7_rdy_b", {127'b0, rdy_b}, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_rdy(0, fa, fb);
        check("resweep_rdy_a", W'(fa), W'(EXP_RDY_A));
        check("resweep_rdy_b", W'(fb), W'(EXP_RDY_B));
        rd_check("after_rst", 4'd3, '0, 1'b1, '0, 1'b1);
`else
        wait_rdy(0, fa, fb);
        check("rerdy_a", W'(fa), W'(EXP_RDY_A));
        check("rerdy_b", W'(fb), W'(EXP_RDY_B));
        rd_check("after_rst", 4'd3, D1, 1'b1, D1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
